// File: rtl/write_cmd_fifo.sv
// write_cmd_fifo: queues host register-write commands {addr, data} and
// replays them downstream as single-cycle write strobes. Backpressure is
// exposed through host_full, and a push that arrives while full is dropped
// and recorded in a sticky overflow flag.
module write_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    host_addr,
  input  logic [31:0]   host_data,
  input  logic          host_write,
  output logic          host_full,
  input  logic          stall,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic [4:0]    write_addr,
  output logic [31:0]   write_data,
  output logic          write,
  output logic [AW:0]   count,
  output logic          overflow
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, drop, pop;

  // Full is judged on the registered count, before any same-cycle pop,
  // so a push at DEPTH is always dropped even when a pop frees a slot.
  assign host_full = (count == FULL_CNT);
  assign push      = host_write && !host_full && !flush;
  assign drop      = host_write &&  host_full && !flush;
  assign pop       = (count != '0) && !stall && !flush;

  // Storage array; contents are don't-care after reset so it has none.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'{addr: host_addr, data: host_data};
  end

  // Pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Registered downstream port: strobe follows the pop decision by one
  // edge, address/data hold their last popped value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write <= pop;
      if (pop) begin
        write_addr <= mem[rd_ptr].addr;
        write_data <= mem[rd_ptr].data;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule
